// File: rtl/hba_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hba_arb_pkg                                                  |
// | Description : Shared constants and FSM encoding for the HBA arbiter.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package hba_arb_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int OWNER_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWNED = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    // Reset value of the round-robin pointer, so master 0 is searched first.
    localparam logic [OWNER_W-1:0] LAST_WINNER_RST = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hba_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hba_rr_pick                                                  |
// | Description : Combinational round-robin pick starting after last_winner.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hba_rr_pick
    import hba_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [OWNER_W-1:0]     last_winner,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [OWNER_W-1:0]     index
);

    logic               found;
    logic [OWNER_W-1:0] cand;

    // Candidate offset NUM_MASTERS wraps back onto last_winner itself.
    always_comb begin
        grant = '0;
        index = last_winner;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = last_winner + OWNER_W'(i);
            if (!found && request[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hba_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hba_rr_arbiter                                               |
// | Description : 4-master round-robin bus arbiter with grant timeout;         |
// |               optional OWNED watchdog when HBA_ARB_WDOG_EN is defined.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hba_rr_arbiter
    import hba_arb_pkg::*;
#(
    parameter int GRANT_TMO   = 15,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset_n,
    input  logic                   hba_select,
    input  logic [NUM_MASTERS-1:0] hba_mrequest,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic [OWNER_W-1:0]     hba_owner,
    output logic                   hba_busy,
    output logic                   hba_grant_tmo,
    output logic                   hba_bus_abort
);

`ifdef HBA_ARB_WDOG_EN
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WDOG_CYCLES - 1);
`else
    localparam int CNT_W = 8;
    // Watchdog depth has no effect in this build; the empty block only keeps it referenced.
    if (WDOG_CYCLES < 1) begin : g_wdog_unused
    end
`endif
    localparam logic [CNT_W-1:0] GRANT_LIMIT = CNT_W'(GRANT_TMO - 1);

    arb_state_t             state, next_state;
    logic [CNT_W-1:0]       cnt, next_cnt, cnt_inc;
    logic [OWNER_W-1:0]     last_winner, next_last;
    logic [OWNER_W-1:0]     next_owner;
    logic [NUM_MASTERS-1:0] next_grant;
    logic                   next_tmo;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [OWNER_W-1:0]     pick_idx;
`ifdef HBA_ARB_WDOG_EN
    logic                   next_abort;
`endif

    hba_rr_pick u_pick (
        .request     (hba_mrequest),
        .last_winner (last_winner),
        .grant       (pick_grant),
        .index       (pick_idx)
    );

    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign hba_busy = (state != ST_IDLE);

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            last_winner   <= LAST_WINNER_RST;
            hba_owner     <= '0;
            hba_mgrant    <= '0;
            hba_grant_tmo <= 1'b0;
`ifdef HBA_ARB_WDOG_EN
            hba_bus_abort <= 1'b0;
`endif
        end else begin
            state         <= next_state;
            cnt           <= next_cnt;
            last_winner   <= next_last;
            hba_owner     <= next_owner;
            hba_mgrant    <= next_grant;
            hba_grant_tmo <= next_tmo;
`ifdef HBA_ARB_WDOG_EN
            hba_bus_abort <= next_abort;
`endif
        end
    end

`ifndef HBA_ARB_WDOG_EN
    assign hba_bus_abort = 1'b0;
`endif

    always_comb begin
        next_state = state;
        next_cnt   = cnt_inc;
        next_last  = last_winner;
        next_owner = hba_owner;
        next_grant = '0;
        next_tmo   = 1'b0;
`ifdef HBA_ARB_WDOG_EN
        next_abort = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                next_cnt = '0;
                if (!hba_select && (|hba_mrequest)) begin
                    next_grant = pick_grant;
                    next_owner = pick_idx;
                    next_last  = pick_idx;
                    next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hba_select) begin
                    next_cnt   = '0;
                    next_state = ST_OWNED;
                end else if (!hba_mrequest[hba_owner] || (cnt == GRANT_LIMIT)) begin
                    // A withdrawn request is handled like an expired grant.
                    next_cnt   = '0;
                    next_tmo   = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_grant = hba_mgrant;
                end
            end
            ST_OWNED: begin
`ifdef HBA_ARB_WDOG_EN
                if (cnt == WDOG_LIMIT) begin
                    next_cnt   = '0;
                    next_abort = 1'b1;
                    next_state = ST_GAP;
                end else if (!hba_select) begin
                    next_cnt   = '0;
                    next_state = ST_GAP;
                end
`else
                next_cnt = '0;
                if (!hba_select) begin
                    next_state = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                next_cnt   = '0;
                next_state = ST_IDLE;
            end
            default: begin
                next_cnt   = '0;
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hba_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hba_rr_arbiter                                            |
// | Description : Directed bench with a cycle model for hba_rr_arbiter.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_hba_rr_arbiter;
    import hba_arb_pkg::*;

    localparam int GT = 15;
    localparam int WD = 8;
`ifdef HBA_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sel = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy, tmo, abort;

    hba_rr_arbiter #(.GRANT_TMO(GT), .WDOG_CYCLES(WD)) dut (
        .hba_clk       (clk),
        .hba_reset_n   (rst_n),
        .hba_select    (sel),
        .hba_mrequest  (req),
        .hba_mgrant    (grant),
        .hba_owner     (owner),
        .hba_busy      (busy),
        .hba_grant_tmo (tmo),
        .hba_bus_abort (abort)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Model: mode 0 free, 1 granted, 2 owned, 3 turnaround.
    int         m_mode, m_age, m_last;
    logic [3:0] e_grant;
    logic [1:0] e_owner;
    logic       e_tmo, e_abort;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_age = 0; m_last = 3;
            e_grant = 4'b0; e_owner = 2'd0; e_tmo = 1'b0; e_abort = 1'b0;
        end else begin
            e_tmo = 1'b0;
            e_abort = 1'b0;
            case (m_mode)
                0: if (!sel && req != 4'b0) begin
                    int w;
                    w = -1;
                    for (int k = 1; k <= 4; k++)
                        if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
                    e_grant = 4'(1 << w);
                    e_owner = 2'(w);
                    m_last  = w;
                    m_mode  = 1;
                    m_age   = 0;
                end
                1: begin
                    m_age++;
                    if (sel) begin
                        e_grant = 4'b0; m_mode = 2; m_age = 0;
                    end else if (!req[e_owner] || m_age >= GT) begin
                        e_grant = 4'b0; e_tmo = 1'b1; m_mode = 0;
                    end
                end
                2: begin
                    m_age++;
                    if (WDOG_ON && m_age >= WD) begin
                        e_abort = 1'b1; m_mode = 3;
                    end else if (!sel) begin
                        m_mode = 3;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if ({grant, owner, busy, tmo, abort} !== {e_grant, e_owner, (m_mode != 0), e_tmo, e_abort}) begin
                errors++;
                $display("FAIL model_cycle t=%0t grant=%b exp=%b owner=%0d exp=%0d busy=%b exp=%b tmo=%b exp=%b abort=%b exp=%b",
                         $time, grant, e_grant, owner, e_owner, busy, (m_mode != 0), tmo, e_tmo, abort, e_abort);
            end
            checks++;
            if (!$onehot0(grant) || (dut.state != ST_GRANT && grant != 4'b0)) begin
                errors++;
                $display("FAIL grant_onehot t=%0t grant=%b state=%0d required onehot0 and zero outside GRANT",
                         $time, grant, dut.state);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int idx, output int waits);
        idx = -1;
        waits = 0;
        for (int i = 0; i < 40 && idx < 0; i++) begin
            @(negedge clk);
            waits++;
            for (int k = 0; k < 4; k++) if (grant[k]) idx = k;
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_wait actual=none expected=grant within 40 cycles");
        end
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int idx, waits, hold, abort_at;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_tmo",   int'(tmo), 0);
        chk("rst_abort", int'(abort), 0);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full contention, each owner holds the bus for 3 cycles.
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(idx, waits);
            chk($sformatf("s1_order_%0d", n), idx, exp_order[n]);
            chk($sformatf("s1_latency_%0d", n), waits, (n == 0) ? 1 : 3);
            sel = 1'b1;
            repeat (3) @(negedge clk);
            sel = 1'b0;
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Silent master 2 times out; master 3 is then ahead of 2.
        req = 4'b0100;
        wait_grant(idx, waits);
        chk("s2_idx", idx, 2);
        hold = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant == 4'b0100) hold++;
            else break;
        end
        chk("s2_hold", hold, GT);
        chk("s2_tmo", int'(tmo), 1);
        req = 4'b1100;
        wait_grant(idx, waits);
        chk("s2_next_idx", idx, 3);
        chk("s2_next_lat", waits, 1);
        req = 4'b0100;
        wait_grant(idx, waits);
        chk("s2_drop_idx", idx, 2);
        chk("s2_drop_lat", waits, 2);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Foreign master on the bus blocks granting.
        sel = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_no_grant", int'(grant), 0);
        end
        sel = 1'b0;
        wait_grant(idx, waits);
        chk("s3_idx", idx, 0);
        chk("s3_lat", waits, 1);

        // Long ownership: watchdog fires only in the watchdog build.
        sel = 1'b1;
        abort_at = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (abort && abort_at < 0) abort_at = i;
        end
        sel = 1'b0;
        req = 4'b0000;
`ifdef HBA_ARB_WDOG_EN
        chk("s4_abort_at", abort_at, WD + 1);
`else
        chk("s4_no_abort", abort_at, -1);
`endif
        repeat (3) @(negedge clk);

        // Reset in the middle of a grant.
        req = 4'b0010;
        wait_grant(idx, waits);
        chk("s5_idx", idx, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_grant_async", int'(grant), 0);
        chk("s5_busy_async", int'(busy), 0);
        repeat (2) @(negedge clk);
        req = 4'b1111;
        rst_n = 1'b1;
        wait_grant(idx, waits);
        chk("s5_first_idx", idx, 0);
        chk("s5_first_lat", waits, 1);
        chk("s5_no_tmo", int'(tmo), 0);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        req = 4'b0000;
        repeat (4) @(negedge clk);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
